// File: rtl/instr_fetch.sv
// Instruction fetch: commands the PC stage, keeps one memory read in flight and buffers
// fetched words in a 2-entry FIFO for decode. Define IFETCH_TIMEOUT_EN to bound WAIT.
package instr_fetch_pkg;
  localparam int unsigned XLEN = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;
endpackage

module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic [XLEN-1:0] I_pc,
  output logic [1:0]      O_pc_op,
  output logic [XLEN-1:0] O_pc_target,
  output logic            O_mem_req,
  output logic [XLEN-1:0] O_mem_addr,
  input  logic            I_mem_ack,
  input  logic [XLEN-1:0] I_mem_data,
  output logic [XLEN-1:0] O_instr,
  output logic [XLEN-1:0] O_instr_pc,
  output logic            O_instr_valid,
  input  logic            I_instr_ready,
  input  logic            I_branch_taken,
  input  logic [XLEN-1:0] I_branch_target,
  input  logic            I_halt,
  output logic            O_fetch_err
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_FULL = 2'd2;

  localparam logic [1:0] ST_CLR   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_LOAD  = 2'b10;
  localparam logic [1:0] PC_CLEAR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       pc_op_q, pc_op_d;
  logic [XLEN-1:0]  pc_target_q, pc_target_d;
  logic             mem_req_q, mem_req_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic             discard_q, discard_d;
  fetch_entry_t     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic             push;
  logic             pop;
  logic             branch;
  logic             pc_pending;
  fetch_entry_t     new_entry;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = 8'd254;

  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
`endif

  assign pop        = valid_q && I_instr_ready;
  assign branch     = I_branch_taken && (state_q != ST_CLR);
  // An increment or load issued last cycle has not reached I_pc yet; a clear after
  // reset only restates the PC stage's own reset value of zero.
  assign pc_pending = (pc_op_q == PC_INC) || (pc_op_q == PC_LOAD);
  assign new_entry  = '{pc: mem_addr_q, word: I_mem_data};

  // Next-state, output and FIFO update logic
  always_comb begin
    state_d     = state_q;
    pc_op_d     = PC_HOLD;
    pc_target_d = pc_target_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    discard_d   = discard_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    push        = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_CLR: begin
        pc_op_d = PC_CLEAR;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!I_halt && !branch && !pc_pending && (count_q != CNT_FULL)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = I_pc;
          state_d    = ST_WAIT;
`ifdef IFETCH_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (I_mem_ack) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = ST_FETCH;
          if (!discard_q) begin
            push    = 1'b1;
            pc_op_d = PC_INC;
          end
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (wait_cnt_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end
`endif
      end
      ST_STALL: begin
        if (pop) state_d = ST_FETCH;
      end
      default: state_d = ST_CLR;
    endcase

    // Head is always entry 0; a pop shifts the tail forward
    case ({push, pop})
      2'b10: begin
        if (count_q == '0) head_d = new_entry;
        else               tail_d = new_entry;
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        if (count_q == CNT_W'(1)) begin
          head_d = new_entry;
        end else begin
          head_d = tail_q;
          tail_d = new_entry;
        end
      end
      default: ;
    endcase

    if (push && (count_d == CNT_FULL)) state_d = ST_STALL;

    // Redirect wins over push/pop; an outstanding read is waited out and dropped
    if (branch) begin
      pc_op_d     = PC_LOAD;
      pc_target_d = I_branch_target;
      count_d     = '0;
      head_d      = head_q;
      tail_d      = tail_q;
      if (mem_req_d) begin
        discard_d = 1'b1;
        state_d   = ST_WAIT;
      end else begin
        state_d   = ST_FETCH;
      end
    end
  end

  // State and output registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_CLR;
      pc_op_q     <= PC_HOLD;
      pc_target_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      discard_q   <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_op_q     <= pc_op_d;
      pc_target_q <= pc_target_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      discard_q   <= discard_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= (count_d != '0);
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign O_fetch_err = err_q;
`else
  assign O_fetch_err = 1'b0;
`endif

  assign O_pc_op       = pc_op_q;
  assign O_pc_target   = pc_target_q;
  assign O_mem_req     = mem_req_q;
  assign O_mem_addr    = mem_addr_q;
  assign O_instr       = head_q.word;
  assign O_instr_pc    = head_q.pc;
  assign O_instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch/stall/branch/halt/reset scenarios, then random
// traffic scored against a PC-stage, memory and program-order decode-stream model.
module tb_instr_fetch;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic [15:0] I_pc = '0;
  logic [1:0]  O_pc_op;
  logic [15:0] O_pc_target;
  logic        O_mem_req;
  logic [15:0] O_mem_addr;
  logic        I_mem_ack = 1'b0;
  logic [15:0] I_mem_data = '0;
  logic [15:0] O_instr;
  logic [15:0] O_instr_pc;
  logic        O_instr_valid;
  logic        I_instr_ready = 1'b0;
  logic        I_branch_taken = 1'b0;
  logic [15:0] I_branch_target = '0;
  logic        I_halt = 1'b0;
  logic        O_fetch_err;

  always #5 I_clk = ~I_clk;

  instr_fetch dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_pc(I_pc),
    .O_pc_op(O_pc_op), .O_pc_target(O_pc_target),
    .O_mem_req(O_mem_req), .O_mem_addr(O_mem_addr),
    .I_mem_ack(I_mem_ack), .I_mem_data(I_mem_data),
    .O_instr(O_instr), .O_instr_pc(O_instr_pc), .O_instr_valid(O_instr_valid),
    .I_instr_ready(I_instr_ready),
    .I_branch_taken(I_branch_taken), .I_branch_target(I_branch_target),
    .I_halt(I_halt), .O_fetch_err(O_fetch_err)
  );

  int errors = 0;
  int checks = 0;
  int n_inc = 0, n_load = 0, n_clr = 0;
  logic [15:0] pc_m = '0;
  bit auto_mem = 1'b0;
  bit acked = 1'b0;
  int lat = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'((a * 16'd3) ^ 16'hA5A5);
  endfunction

  // One clock: PC stage applies the command visible before the edge; optional memory responder
  task automatic step();
    logic [1:0]  op;
    logic [15:0] tgt;
    op  = O_pc_op;
    tgt = O_pc_target;
    @(posedge I_clk);
    #1;
    if (!I_rst_n) pc_m = '0;
    else begin
      case (op)
        2'b01:   pc_m = 16'(pc_m + 16'd1);
        2'b10:   pc_m = tgt;
        2'b11:   pc_m = '0;
        default: ;
      endcase
    end
    I_pc = pc_m;
    if (O_pc_op == 2'b01) n_inc++;
    if (O_pc_op == 2'b10) n_load++;
    if (O_pc_op == 2'b11) n_clr++;
    if (auto_mem) begin
      if (!O_mem_req) begin
        acked = 1'b0; I_mem_ack = 1'b0; lat = $urandom_range(0, 3);
      end else if (acked) begin
        I_mem_ack = 1'b0;
      end else if (lat == 0) begin
        I_mem_ack = 1'b1; I_mem_data = mem_word(O_mem_addr); acked = 1'b1;
      end else begin
        lat--; I_mem_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n;
    n = 0;
    while (!O_mem_req && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 32'(O_mem_req), 32'd1);
  endtask

  task automatic ack_with(input logic [15:0] data);
    I_mem_ack = 1'b1; I_mem_data = data;
    step();
    I_mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int inc0, ld0, clr0, pops;
    logic [15:0] exp_pc;
    bit br;

    repeat (3) step();
    chk("rst_pc_op", 32'(O_pc_op), 32'd0);
    chk("rst_mem_req", 32'(O_mem_req), 32'd0);
    chk("rst_mem_addr", 32'(O_mem_addr), 32'd0);
    chk("rst_valid", 32'(O_instr_valid), 32'd0);
    chk("rst_instr", 32'(O_instr), 32'd0);
    chk("rst_instr_pc", 32'(O_instr_pc), 32'd0);
    chk("rst_target", 32'(O_pc_target), 32'd0);
    chk("rst_err", 32'(O_fetch_err), 32'd0);

    // Release: one clear cycle, then the first request at 0
    I_rst_n = 1'b1;
    step();
    chk("clr_op", 32'(O_pc_op), 32'd3);
    chk("clr_req", 32'(O_mem_req), 32'd0);
    step();
    chk("first_req", 32'(O_mem_req), 32'd1);
    chk("first_addr", 32'(O_mem_addr), 32'd0);
    chk("clr_once", 32'(O_pc_op), 32'd0);

    inc0 = n_inc;
    ack_with(16'hA5A5);
    chk("ack_op", 32'(O_pc_op), 32'd1);
    chk("ack_valid", 32'(O_instr_valid), 32'd1);
    chk("ack_instr", 32'(O_instr), 32'hA5A5);
    chk("ack_instr_pc", 32'(O_instr_pc), 32'd0);
    chk("ack_req_drop", 32'(O_mem_req), 32'd0);
    wait_req("req1", 8);
    chk("req1_addr", 32'(O_mem_addr), 32'd1);
    chk("inc_once", 32'(n_inc - inc0), 32'd1);

    // Fill the FIFO with decode stalled
    ack_with(mem_word(16'd1));
    chk("full_op", 32'(O_pc_op), 32'd1);
    repeat (4) step();
    chk("stall_req", 32'(O_mem_req), 32'd0);
    chk("stall_valid", 32'(O_instr_valid), 32'd1);
    chk("stall_head", 32'(O_instr), 32'hA5A5);
    chk("stall_head_pc", 32'(O_instr_pc), 32'd0);
    I_instr_ready = 1'b1;
    step();
    I_instr_ready = 1'b0;
    chk("pop_head_pc", 32'(O_instr_pc), 32'd1);
    chk("pop_head", 32'(O_instr), 32'(mem_word(16'd1)));
    step();
    chk("unstall_req", 32'(O_mem_req), 32'd1);
    chk("unstall_addr", 32'(O_mem_addr), 32'd2);

    // Push and pop together with one entry held
    I_instr_ready = 1'b1;
    ack_with(mem_word(16'd2));
    I_instr_ready = 1'b0;
    chk("pp_valid", 32'(O_instr_valid), 32'd1);
    chk("pp_pc", 32'(O_instr_pc), 32'd2);
    chk("pp_word", 32'(O_instr), 32'(mem_word(16'd2)));
    chk("pp_op", 32'(O_pc_op), 32'd1);

    // Branch while waiting; the late ack is dropped
    wait_req("req3", 8);
    chk("req3_addr", 32'(O_mem_addr), 32'd3);
    inc0 = n_inc;
    ld0  = n_load;
    I_branch_taken = 1'b1; I_branch_target = 16'h0040;
    step();
    I_branch_taken = 1'b0;
    chk("br_flush", 32'(O_instr_valid), 32'd0);
    chk("br_op", 32'(O_pc_op), 32'd2);
    chk("br_tgt", 32'(O_pc_target), 32'h40);
    chk("br_hold_req", 32'(O_mem_req), 32'd1);
    chk("br_hold_addr", 32'(O_mem_addr), 32'd3);
    repeat (2) step();
    ack_with(mem_word(16'd3));
    chk("drop_valid", 32'(O_instr_valid), 32'd0);
    chk("drop_req", 32'(O_mem_req), 32'd0);
    wait_req("req40", 8);
    chk("req40_addr", 32'(O_mem_addr), 32'h40);
    chk("drop_no_inc", 32'(n_inc - inc0), 32'd0);
    chk("br_one_load", 32'(n_load - ld0), 32'd1);
    ack_with(mem_word(16'h40));
    chk("br_head_pc", 32'(O_instr_pc), 32'h40);
    chk("br_head", 32'(O_instr), 32'(mem_word(16'h40)));

    // Halt blocks new requests
    I_halt = 1'b1;
    repeat (6) step();
    chk("halt_req", 32'(O_mem_req), 32'd0);
    I_halt = 1'b0;
    wait_req("halt_rel", 8);
    chk("halt_rel_addr", 32'(O_mem_addr), 32'h41);

`ifdef IFETCH_TIMEOUT_EN
    repeat (254) step();
    chk("tmo_early", 32'(O_fetch_err), 32'd0);
    chk("tmo_early_req", 32'(O_mem_req), 32'd1);
    step();
    chk("tmo_err", 32'(O_fetch_err), 32'd1);
    chk("tmo_req", 32'(O_mem_req), 32'd0);
    wait_req("tmo_retry", 8);
    chk("tmo_retry_addr", 32'(O_mem_addr), 32'h41);
    ack_with(mem_word(16'h41));
    repeat (10) step();
    chk("tmo_sticky", 32'(O_fetch_err), 32'd1);
`else
    repeat (300) step();
    chk("no_tmo_req", 32'(O_mem_req), 32'd1);
    chk("no_tmo_err", 32'(O_fetch_err), 32'd0);
    ack_with(mem_word(16'h41));
`endif

    // Reset mid-request; acks around the release are ignored
    I_instr_ready = 1'b1;
    repeat (2) step();
    I_instr_ready = 1'b0;
    wait_req("pre_rst", 8);
    I_rst_n = 1'b0;
    #1;
    chk("rst_abandon", 32'(O_mem_req), 32'd0);
    chk("rst_flush", 32'(O_instr_valid), 32'd0);
    I_mem_ack = 1'b1; I_mem_data = 16'hDEAD;
    repeat (2) step();
    I_rst_n = 1'b1;
    step();
    chk("rst_clr_op", 32'(O_pc_op), 32'd3);
    chk("rst_ack_ign", 32'(O_instr_valid), 32'd0);
    step();
    I_mem_ack = 1'b0;
    chk("rst_ack_ign2", 32'(O_instr_valid), 32'd0);
    chk("rst_req", 32'(O_mem_req), 32'd1);
    chk("rst_addr", 32'(O_mem_addr), 32'd0);
    chk("rst_err_clear", 32'(O_fetch_err), 32'd0);

    // Random traffic: decode must see program order from 0, restarting at each target
    auto_mem = 1'b1; acked = 1'b0; lat = 1;
    exp_pc = 16'h0000;
    pops = 0;
    clr0 = n_clr;
    for (int i = 0; i < 3000; i++) begin
      I_instr_ready   = ($urandom_range(0, 1) == 1);
      I_halt          = ($urandom_range(0, 9) == 0);
      br              = ($urandom_range(0, 19) == 0);
      I_branch_taken  = br;
      I_branch_target = 16'($urandom);
      if (br) begin
        exp_pc = I_branch_target;
      end else if (O_instr_valid && I_instr_ready) begin
        chk("rnd_pc", 32'(O_instr_pc), 32'(exp_pc));
        chk("rnd_word", 32'(O_instr), 32'(mem_word(O_instr_pc)));
        exp_pc = 16'(O_instr_pc + 16'd1);
        pops++;
      end
      step();
      if (br) chk("rnd_flush", 32'(O_instr_valid), 32'd0);
    end
    I_branch_taken = 1'b0;
    chk("rnd_progress", 32'(pops >= 100), 32'd1);
    chk("rnd_no_clear", 32'(n_clr - clr0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
